// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the hex_scan_ctrl display scan controller.
// Optional deadband filtering is enabled with HEX_SCAN_DEADBAND_EN.
package hex_scan_pkg;

    localparam int POS_W = 32;
    localparam logic [POS_W-1:0] DEF_RESET_POS = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        COMMIT,
        BLANK,
        SHOW
    } state_e;

    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Loadable down-counter used to time the blank and show phases of a slot.
module hex_scan_timer
    import hex_scan_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller: shadows per-channel positions, commits one
// per slot and drives active-low digit enables. HEX_SCAN_DEADBAND_EN adds jitter filtering.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int               NUM_CH    = 2,
    parameter int               CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int               SHOW_CYC  = 49499,
    parameter int               BLANK_CYC = 500,
    parameter logic [POS_W-1:0] RESET_POS = DEF_RESET_POS,
    parameter int               DEADBAND  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CHW-1:0]    in_ch,
    input  logic [POS_W-1:0]  in_pos,
    output logic              in_ready,
    output logic [POS_W-1:0]  pos_out,
    output logic [CHW-1:0]    scan_ch,
    output logic [NUM_CH-1:0] dig_en_n,
    output logic              blank,
    output logic              frame_tick,
    output logic              err_oob
);

    localparam int MAXC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e               state_q, state_d;
    logic [CHW-1:0]       scan_q, scan_d;
    logic [POS_W-1:0]     shadow_q [NUM_CH];
    logic [POS_W-1:0]     active_q [NUM_CH];
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [NUM_CH-1:0]    dig_q, dig_d;
    logic                 blank_q, blank_d;
    logic                 rdy_q, rdy_d;
    logic                 ft_q, ft_d;
    logic                 err_q, err_d;

    logic                 t_load, t_done;
    logic [TW-1:0]        t_val;
    logic [POS_W-1:0]     sh_scan;
    logic                 accept, in_range, wr_ok;

    hex_scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        sh_scan = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (scan_q == CHW'(i)) sh_scan = shadow_q[i];
    end

    assign accept   = in_valid && rdy_q;
    assign in_range = (POS_W'(in_ch) < POS_W'(NUM_CH));

`ifdef HEX_SCAN_DEADBAND_EN
    logic [POS_W-1:0] sh_in;
    always_comb begin
        sh_in = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (in_ch == CHW'(i)) sh_in = shadow_q[i];
    end
    // A channel still at its reset value always takes the first real update.
    assign wr_ok = (abs_diff(in_pos, sh_in) >= POS_W'(DEADBAND)) || (sh_in == RESET_POS);
`else
    logic unused_deadband;
    assign unused_deadband = ^DEADBAND;
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        t_load  = 1'b0;
        t_val   = '0;
        pos_d   = pos_q;
        ft_d    = 1'b0;
        case (state_q)
            COMMIT: begin
                state_d = BLANK;
                t_load  = 1'b1;
                t_val   = TW'(BLANK_CYC - 1);
                pos_d   = sh_scan;
            end
            BLANK: begin
                if (t_done) begin
                    state_d = SHOW;
                    t_load  = 1'b1;
                    t_val   = TW'(SHOW_CYC - 1);
                end
            end
            SHOW: begin
                if (t_done) begin
                    state_d = COMMIT;
                    if (scan_q == CHW'(NUM_CH - 1)) begin
                        scan_d = '0;
                        ft_d   = 1'b1;
                    end else begin
                        scan_d = scan_q + CHW'(1);
                    end
                end
            end
            default: state_d = COMMIT;
        endcase
        // Outputs are registered from the next state so they line up with it.
        rdy_d   = (state_d != COMMIT);
        blank_d = (state_d != SHOW);
        for (int i = 0; i < NUM_CH; i++)
            dig_d[i] = !((state_d == SHOW) && (scan_d == CHW'(i)));
        err_d = err_q | (accept & ~in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COMMIT;
            scan_q  <= '0;
            pos_q   <= RESET_POS;
            dig_q   <= '1;
            blank_q <= 1'b1;
            rdy_q   <= 1'b0;
            ft_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RESET_POS;
                active_q[i] <= RESET_POS;
            end
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            pos_q   <= pos_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            rdy_q   <= rdy_d;
            ft_q    <= ft_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && in_range && wr_ok && (in_ch == CHW'(i)))
                    shadow_q[i] <= in_pos;
                if ((state_q == COMMIT) && (scan_q == CHW'(i)))
                    active_q[i] <= shadow_q[i];
            end
        end
    end

    assign in_ready   = rdy_q;
    assign pos_out    = pos_q;
    assign scan_ch    = scan_q;
    assign dig_en_n   = dig_q;
    assign blank      = blank_q;
    assign frame_tick = ft_q;
    assign err_oob    = err_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized scoreboard bench for hex_scan_ctrl; the reference derives all timing from the cycle count.
module tb_hex_scan_ctrl;

    localparam int NUM_CH = 2;
    localparam int CHW    = 2;
    localparam int BLK    = 2;
    localparam int SHW    = 4;
    localparam int DB     = 4;
    localparam int SLOT   = 1 + BLK + SHW;
    localparam logic [31:0] RPOS = 32'hFFFF_FFFF;

    logic              clk = 0;
    logic              rst = 1;
    logic              in_valid = 0;
    logic [CHW-1:0]    in_ch = '0;
    logic [31:0]       in_pos = '0;
    logic              in_ready;
    logic [31:0]       pos_out;
    logic [CHW-1:0]    scan_ch;
    logic [NUM_CH-1:0] dig_en_n;
    logic              blank, frame_tick, err_oob;

    hex_scan_ctrl #(
        .NUM_CH(NUM_CH), .CHW(CHW), .SHOW_CYC(SHW), .BLANK_CYC(BLK), .DEADBAND(DB)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_pos(in_pos),
        .in_ready(in_ready), .pos_out(pos_out), .scan_ch(scan_ch), .dig_en_n(dig_en_n),
        .blank(blank), .frame_tick(frame_tick), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          t = 0;
    bit          started = 0;
    logic [31:0] m_sh [NUM_CH];
    bit          m_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] cur_exp = RPOS;
    bit          prev_rdy = 0;
    logic [31:0] last_pos [NUM_CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
        end
    endtask

    // Reference model: slot phase and channel follow from cycles since reset.
    always @(posedge clk) begin
        if (rst) begin
            t = 0; m_err = 0; started = 1;
            for (int i = 0; i < NUM_CH; i++) m_sh[i] = RPOS;
            exp_q.delete();
        end else if (started) begin
            int p, ch;
            p  = t % SLOT;
            ch = (t / SLOT) % NUM_CH;
            if (p == 0) exp_q.push_back(m_sh[ch]);
            else if (in_valid) begin
                if (int'(in_ch) >= NUM_CH) m_err = 1;
                else begin
                    bit ok;
                    logic [31:0] old, d;
                    old = m_sh[in_ch];
                    d   = (in_pos > old) ? in_pos - old : old - in_pos;
`ifdef HEX_SCAN_DEADBAND_EN
                    ok = (d >= DB) || (old == RPOS);
`else
                    ok = 1'b1;
                    if (d == 0) ok = 1'b1;
`endif
                    if (ok) m_sh[in_ch] = in_pos;
                end
            end
            t++;
        end
    end

    // Monitor: per-cycle timing checks plus commit scoreboard on in_ready rising.
    always @(negedge clk) begin
        if (started) begin
            int p, ch;
            logic [NUM_CH-1:0] e_dig;
            p  = t % SLOT;
            ch = (t / SLOT) % NUM_CH;
            if (t == 0) cur_exp = RPOS;
            if (in_ready && !prev_rdy) begin
                if (exp_q.size() == 0) chk("commit_queue_empty", 32'd1, 32'd0);
                else begin
                    cur_exp = exp_q.pop_front();
                    chk("commit_ch", 32'(scan_ch), 32'(ch));
                end
            end
            prev_rdy = in_ready;
            e_dig = '1;
            if (p > BLK) e_dig[ch] = 1'b0;
            chk("pos_out",    pos_out, cur_exp);
            chk("dig_en_n",   32'(dig_en_n), 32'(e_dig));
            chk("blank",      32'(blank), 32'(p <= BLK));
            chk("in_ready",   32'(in_ready), 32'(p != 0));
            chk("scan_ch",    32'(scan_ch), 32'(ch));
            chk("frame_tick", 32'(frame_tick), 32'(t != 0 && p == 0 && ch == 0));
            chk("err_oob",    32'(err_oob), 32'(m_err));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((t % SLOT) != p && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("wait_phase_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr(input int ch, input logic [31:0] pos);
        bit acc = 0;
        int n = 0;
        in_valid = 1; in_ch = CHW'(ch); in_pos = pos;
        while (!acc && n < 100) begin
            acc = in_ready;
            @(posedge clk); #1; n++;
        end
        if (!acc) chk("handshake_timeout", 32'd1, 32'd0);
        in_valid = 0;
        if (ch < NUM_CH) last_pos[ch] = pos;
    endtask

    task automatic pulse_rst;
        rst = 1; idle(1); rst = 0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) last_pos[i] = 32'd0;
        idle(3);
        rst = 0;
        idle(30);
        wait_phase(BLK + 2);            // inside ch0 or ch1 show
        while (((t / SLOT) % NUM_CH) != 0) begin idle(SLOT); end
        wr(1, 32'd600);
        idle(20);
        wr(0, 32'd300);
        wr(0, 32'd700);
        idle(15);
        wait_phase(0);                  // request held across a commit
        wr(1, 32'd1234);
        idle(10);
        wr(3, 32'd55);
        idle(10);
        pulse_rst();
        idle(10);
        wr(0, 32'd500); idle(16);
        wr(0, 32'd502); idle(16);
        wr(0, 32'd505); idle(16);
        for (int k = 0; k < 80; k++) begin
            int ch;
            logic [31:0] pos;
            idle($urandom_range(0, 5));
            ch = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, NUM_CH - 1);
            if (ch < NUM_CH && $urandom_range(0, 1) == 1)
                pos = last_pos[ch] + 32'($urandom_range(0, 8)) - 32'd4;
            else
                pos = $urandom;
            wr(ch, pos);
            if (k == 40) begin
                wait_phase(4);
                pulse_rst();
            end
        end
        idle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
